// File: rtl/xml_pkg.sv
// Shared types and widths for the XML element extractor.
package xml_pkg;

  localparam int unsigned DEPTH_W   = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CFG_LEN_W = 5;
  localparam int unsigned COUNT_W   = 8;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_NAME,
    ST_ARMED,
    ST_CAPTURE
  } state_e;

  // One emitted value byte with its framing flags.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              start;
    logic              last;
  } beat_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/xml_name_cmp.sv
// Serial tag-name comparator: tracks byte index and running equality against
// the programmed target name; o_match_c reports a full-length exact match.
module xml_name_cmp
  import xml_pkg::*;
#(
  parameter int unsigned NAME_MAX = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_step,
  input  logic [BYTE_W-1:0]          i_byte,
  input  logic [BYTE_W*NAME_MAX-1:0] i_cfg_name,
  input  logic [CFG_LEN_W-1:0]       i_cfg_len,
  output logic                       o_match_c
);

  localparam int unsigned IDX_W = $clog2(NAME_MAX + 2);
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(NAME_MAX + 1);

  logic [IDX_W-1:0]  r_idx;
  logic              r_eq;
  logic              w_in_range;
  logic [BYTE_W-1:0] w_ref;

  // Reference byte at the current index (zero once past the name buffer).
  always_comb begin
    w_in_range = (32'(r_idx) < NAME_MAX);
    w_ref      = '0;
    for (int unsigned k = 0; k < NAME_MAX; k++) begin
      if (32'(r_idx) == k) w_ref = i_cfg_name[BYTE_W*k +: BYTE_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx <= '0;
      r_eq  <= 1'b0;
    end else if (i_start) begin
      r_idx <= IDX_W'(1);
      r_eq  <= (i_byte == i_cfg_name[BYTE_W-1:0]);
    end else if (i_step) begin
      r_eq <= r_eq && w_in_range && (i_byte == w_ref);
      if (r_idx != IDX_SAT) r_idx <= r_idx + IDX_W'(1);
    end
  end

  assign o_match_c = r_eq && (i_cfg_len != '0) && (32'(r_idx) == 32'(i_cfg_len));

endmodule

// File: rtl/xml_element_extract.sv
// Extracts the text content of a target element (name + depth) from the
// classified decoder byte stream as a framed byte run, one valid byte behind.
module xml_element_extract
  import xml_pkg::*;
#(
  parameter int unsigned NAME_MAX  = 16,
  parameter int unsigned VALUE_MAX = 64
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_new_msg,
  input  logic [BYTE_W-1:0]          i_in,
  input  logic                       i_in_valid,
  input  logic                       i_is_data,
  input  logic                       i_is_tag,
  input  logic                       i_is_tag_name,
  input  logic                       i_is_comment,
  input  logic                       i_depth_pop,
  input  logic [DEPTH_W-1:0]         i_tag_depth,
  input  logic [BYTE_W*NAME_MAX-1:0] i_cfg_name,
  input  logic [CFG_LEN_W-1:0]       i_cfg_len,
  input  logic [DEPTH_W-1:0]         i_cfg_depth,
  output logic [BYTE_W-1:0]          o_out,
  output logic                       o_out_valid,
  output logic                       o_out_start,
  output logic                       o_out_end,
  output logic                       o_overflow,
  output logic [COUNT_W-1:0]         o_match_count
);

  localparam int unsigned CNT_W = $clog2(VALUE_MAX + 1);

  state_e            r_state, w_next;
  logic              r_closing, w_closing_nxt;
  logic [BYTE_W-1:0] r_hold;
  logic              r_first;
  logic [CNT_W-1:0]  r_cnt;
  beat_t             r_beat;
  logic              r_out_valid;
  logic              r_overflow;
  logic [COUNT_W-1:0] r_match_count;

  logic w_match_c, w_cmp_start, w_cmp_step;
  logic w_emit, w_end, w_load, w_arm_load, w_drop, w_term;

  xml_name_cmp #(.NAME_MAX(NAME_MAX)) u_name_cmp (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (w_cmp_start),
    .i_step     (w_cmp_step),
    .i_byte     (i_in),
    .i_cfg_name (i_cfg_name),
    .i_cfg_len  (i_cfg_len),
    .o_match_c  (w_match_c)
  );

  // Next state and per-byte actions; only valid, non-restart bytes act.
  always_comb begin
    w_next        = r_state;
    w_closing_nxt = r_closing;
    w_cmp_start   = 1'b0;
    w_cmp_step    = 1'b0;
    w_emit        = 1'b0;
    w_end         = 1'b0;
    w_load        = 1'b0;
    w_arm_load    = 1'b0;
    w_drop        = 1'b0;
    w_term        = i_is_tag || i_is_comment || i_depth_pop;
    if (i_in_valid && !i_new_msg) begin
      case (r_state)
        ST_SCAN: begin
          if (i_is_tag_name && (i_cfg_len != '0)) begin
            w_next        = ST_NAME;
            w_cmp_start   = 1'b1;
            w_closing_nxt = i_depth_pop;
          end
        end
        ST_NAME: begin
          if (i_is_tag_name) begin
            w_cmp_step    = 1'b1;
            w_closing_nxt = r_closing || i_depth_pop;
          end else if (w_match_c && !(r_closing || i_depth_pop) &&
                       (i_tag_depth == i_cfg_depth)) begin
            w_next = ST_ARMED;
          end else begin
            w_next = ST_SCAN;
          end
        end
        ST_ARMED: begin
          if (i_depth_pop) begin
            w_next = ST_SCAN;
          end else if (i_is_tag_name) begin
            w_next        = ST_NAME;
            w_cmp_start   = 1'b1;
            w_closing_nxt = 1'b0;
          end else if (i_is_data) begin
            w_next     = ST_CAPTURE;
            w_load     = 1'b1;
            w_arm_load = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (w_term) begin
            w_emit        = 1'b1;
            w_end         = 1'b1;
            w_next        = i_is_tag_name ? ST_NAME : ST_SCAN;
            w_cmp_start   = i_is_tag_name;
            w_closing_nxt = i_depth_pop;
          end else if (i_is_data) begin
            if (32'(r_cnt) < VALUE_MAX) begin
              w_emit = 1'b1;
              w_load = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
        default: w_next = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_SCAN;
      r_closing     <= 1'b0;
      r_hold        <= '0;
      r_first       <= 1'b0;
      r_cnt         <= '0;
      r_beat        <= '0;
      r_out_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_beat.data  <= r_hold;
        r_beat.start <= r_first;
        r_beat.last  <= w_end;
      end else begin
        r_beat <= '0;
      end
      if (i_new_msg) begin
        r_state   <= ST_SCAN;
        r_closing <= 1'b0;
        r_hold    <= '0;
        r_first   <= 1'b0;
        r_cnt     <= '0;
      end else if (i_in_valid) begin
        r_state   <= w_next;
        r_closing <= w_closing_nxt;
        if (w_load) begin
          r_hold <= i_in;
          r_cnt  <= w_arm_load ? CNT_W'(1) : r_cnt + CNT_W'(1);
        end
        if (w_arm_load)  r_first <= 1'b1;
        else if (w_emit) r_first <= 1'b0;
        if (w_drop) r_overflow <= 1'b1;
        if (w_end)  r_match_count <= sat_inc(r_match_count);
      end
    end
  end

  assign o_out         = r_beat.data;
  assign o_out_start   = r_beat.start;
  assign o_out_end     = r_beat.last;
  assign o_out_valid   = r_out_valid;
  assign o_overflow    = r_overflow;
  assign o_match_count = r_match_count;

endmodule

// File: tb/tb_xml_element_extract.sv
// Scoreboard bench: a small decoder model classifies XML text, expected value
// beats are queued per DUT and a negedge monitor checks every emitted byte.
module tb_xml_element_extract;
  import xml_pkg::*;

  localparam int unsigned NM = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, new_msg;
  logic [7:0]    in_byte;
  logic          valid_a, valid_b;
  logic          is_data, is_tag, is_tag_name, is_comment, depth_pop;
  logic [3:0]    tag_depth;
  logic [8*NM-1:0] cfg_name;
  logic [4:0]    cfg_len;
  logic [3:0]    cfg_depth;

  logic [7:0] out_a, out_b, mc_a, mc_b;
  logic       ov_a, ov_b, os_a, os_b, oe_a, oe_b, ovf_a, ovf_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  xml_element_extract dut_a (
    .i_clk(clk), .i_reset(reset), .i_new_msg(new_msg), .i_in(in_byte),
    .i_in_valid(valid_a), .i_is_data(is_data), .i_is_tag(is_tag),
    .i_is_tag_name(is_tag_name), .i_is_comment(is_comment),
    .i_depth_pop(depth_pop), .i_tag_depth(tag_depth), .i_cfg_name(cfg_name),
    .i_cfg_len(cfg_len), .i_cfg_depth(cfg_depth), .o_out(out_a),
    .o_out_valid(ov_a), .o_out_start(os_a), .o_out_end(oe_a),
    .o_overflow(ovf_a), .o_match_count(mc_a)
  );

  xml_element_extract #(.VALUE_MAX(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_new_msg(new_msg), .i_in(in_byte),
    .i_in_valid(valid_b), .i_is_data(is_data), .i_is_tag(is_tag),
    .i_is_tag_name(is_tag_name), .i_is_comment(is_comment),
    .i_depth_pop(depth_pop), .i_tag_depth(tag_depth), .i_cfg_name(cfg_name),
    .i_cfg_len(cfg_len), .i_cfg_depth(cfg_depth), .o_out(out_b),
    .o_out_valid(ov_b), .o_out_start(os_b), .o_out_end(oe_b),
    .o_overflow(ovf_b), .o_match_count(mc_b)
  );

  // Monitor: every emitted byte must match the head of that DUT's queue.
  always @(negedge clk) begin
    exp_t x;
    if (ov_a) begin
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL out_a unexpected: got byte %h start %0b end %0b", out_a, os_a, oe_a);
      end else begin
        x = q_a.pop_front();
        if ({out_a, os_a, oe_a} !== x) begin
          n_fail++;
          $display("FAIL out_a beat: got %h/%0b/%0b expected %h/%0b/%0b",
                   out_a, os_a, oe_a, x.d, x.s, x.e);
        end
      end
    end
    if (ov_b) begin
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL out_b unexpected: got byte %h start %0b end %0b", out_b, os_b, oe_b);
      end else begin
        x = q_b.pop_front();
        if ({out_b, os_b, oe_b} !== x) begin
          n_fail++;
          $display("FAIL out_b beat: got %h/%0b/%0b expected %h/%0b/%0b",
                   out_b, os_b, oe_b, x.d, x.s, x.e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic va, input logic vb, input logic nm, input logic [7:0] c,
                       input logic dat, input logic tg, input logic tn, input logic pop,
                       input int dep);
    @(negedge clk);
    valid_a = va; valid_b = vb; new_msg = nm; in_byte = c;
    is_data = dat; is_tag = tg; is_tag_name = tn; is_comment = 1'b0;
    depth_pop = pop; tag_depth = 4'(dep);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic set_cfg(input string nm, input int dep);
    cfg_name = '0;
    for (int i = 0; i < nm.len(); i++) cfg_name[8*i +: 8] = nm[i];
    cfg_len   = 5'(nm.len());
    cfg_depth = 4'(dep);
  endtask

  task automatic expect_val(input bit to_b, input string v);
    exp_t x;
    for (int i = 0; i < v.len(); i++) begin
      x.d = v[i];
      x.s = (i == 0);
      x.e = (i == v.len() - 1);
      if (to_b) q_b.push_back(x);
      else      q_a.push_back(x);
    end
  endtask

  // Decoder model: classifies each character and tracks depth.
  task automatic send_msg(input string s, input bit to_b, input bit gaps);
    int   depth   = 0;
    bit   in_tag  = 0;
    bit   closing = 0;
    bit   name_ph = 0;
    logic [7:0] prev = 8'h00;
    logic [7:0] c, nx;
    logic dat, tg, tn, pop;
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < s.len(); i++) begin
      c   = s[i];
      nx  = (i + 1 < s.len()) ? s[i+1] : 8'h00;
      dat = 0; tg = 0; tn = 0; pop = 0;
      if (c == "<") begin
        tg = 1; in_tag = 1; name_ph = 1;
        closing = (nx == "/");
        if (!closing) depth++;
      end else if (in_tag) begin
        tg = 1;
        if (c == ">") begin
          in_tag = 0;
          pop = closing || (prev == "/");
        end else if (c == "/") begin
          if (prev != "<") name_ph = 0;
        end else if (name_ph && c != " ") begin
          tn = 1;
        end else begin
          name_ph = 0;
        end
      end else begin
        dat = 1;
      end
      drive(!to_b, to_b, 1'b0, c, dat, tg, tn, pop, depth);
      if (pop) depth--;
      if (gaps) idle(1);
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1;
    set_cfg("px", 1);
    idle(2);
    check("reset out_valid", 32'(ov_a), 0);
    check("reset match_count", 32'(mc_a), 0);
    check("reset overflow", 32'(ovf_a), 0);
    reset = 1'b0;
    idle(1);

    // T1 basic extraction
    expect_val(0, "101.5");
    send_msg("<px>101.5</px>", 0, 0);
    check("t1 match_count", 32'(mc_a), 1);
    check("t1 overflow", 32'(ovf_a), 0);
    check("t1 queue drained", 32'(q_a.size()), 0);

    // T2 repeated child at depth 2
    set_cfg("b", 2);
    expect_val(0, "7");
    expect_val(0, "89");
    send_msg("<a><b>7</b><b>89</b></a>", 0, 0);
    check("t2 match_count", 32'(mc_a), 3);
    check("t2 queue drained", 32'(q_a.size()), 0);

    // T3 shorter name and prefix-extended name must not match
    set_cfg("px", 1);
    send_msg("<p>1</p><pxx>2</pxx>", 0, 0);
    check("t3 match_count", 32'(mc_a), 3);

    // T4 wrong depth, then self-closing element at the right depth
    set_cfg("b", 1);
    send_msg("<a><b>3</b></a>", 0, 0);
    set_cfg("b", 2);
    send_msg("<a><b/></a>", 0, 0);
    check("t4 match_count", 32'(mc_a), 3);

    // T6 input gaps give identical output
    set_cfg("px", 1);
    expect_val(0, "101.5");
    send_msg("<px>101.5</px>", 0, 1);
    check("t6 gaps match_count", 32'(mc_a), 4);
    check("t6 queue drained", 32'(q_a.size()), 0);

    // Reset in the middle of a value: first byte out, then nothing more
    begin
      exp_t x;
      x.d = "1"; x.s = 1'b1; x.e = 1'b0;
      q_a.push_back(x);
    end
    send_msg("<px>12", 0, 0);
    reset = 1'b1;
    idle(1);
    check("mid reset out_valid", 32'(ov_a), 0);
    check("mid reset out_end", 32'(oe_a), 0);
    check("mid reset match_count", 32'(mc_a), 0);
    reset = 1'b0;
    idle(1);
    expect_val(0, "101.5");
    send_msg("<px>101.5</px>", 0, 0);
    check("post reset match_count", 32'(mc_a), 1);
    check("post reset queue drained", 32'(q_a.size()), 0);

    // T5 overflow on the VALUE_MAX=4 instance, sticky across a later value
    check("t5 overflow before", 32'(ovf_b), 0);
    expect_val(1, "1234");
    send_msg("<px>123456</px>", 1, 0);
    check("t5 overflow", 32'(ovf_b), 1);
    check("t5 match_count", 32'(mc_b), 1);
    expect_val(1, "12");
    send_msg("<px>12</px>", 1, 0);
    check("t5 overflow sticky", 32'(ovf_b), 1);
    check("t5 match_count 2", 32'(mc_b), 2);
    check("t5 queue drained", 32'(q_b.size()), 0);
    check("dut_a overflow untouched", 32'(ovf_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
